// File: rtl/online_div_sequencer.sv
// -----------------------------------------------------------------------------
// online_div_sequencer
//
// Control sequencer for a digit-serial (online) radix-2 signed-digit divider.
// It accepts one dividend/divisor digit pair per enable cycle and tells the
// datapath when to step. It also provides register-file addresses and shift
// counts, and captures the quotient digit that the datapath selects.
//
// A division runs through the phases IDLE -> PRELOAD -> ITERATE -> FLUSH -> DONE:
//   PRELOAD  : the first ONLINE_DELAY operand digits are consumed. No quotient
//              digit is produced in this phase.
//   ITERATE  : operand digits are still consumed, and each step also yields a
//              quotient digit.
//   FLUSH    : no operand digits remain. The datapath steps every cycle to
//              drain the last ONLINE_DELAY quotient digits.
//   DONE     : a single cycle with done high.
//
// Digit encoding (2 bits): 10 = +1, 01 = -1, 00 = 0, 11 = 0 (normalised to 00).
//
// Optional feature (compile-time macro):
//   DIV_STALL_CNT_EN : adds output stall_cnt. It counts the cycles in which
//                      operands were wanted but in_valid was low. It clears on
//                      refresh and saturates at 16'hFFFF.
//
// Ports:
//   clk          : clock; all flops use the rising edge
//   asyn_reset   : asynchronous reset, active low
//   start        : request a new division (honoured only in IDLE)
//   x_value      : dividend digit
//   d_value      : divisor digit
//   in_valid     : an operand digit pair is present
//   in_ready     : operand pair is accepted when in_valid & in_ready
//   q_dp         : quotient digit chosen by the datapath in this enable cycle
//   enable       : datapath step strobe
//   refresh      : one-cycle pulse when a division is launched
//   counter      : number of datapath steps taken in this division
//   shift_cnt    : counter - ONLINE_DELAY, floored at 0
//   wr_addr      : register-file write address (low bits of counter)
//   rd_addr      : wr_addr - 1, wrapping modulo 2^ADDR_WIDTH
//   x_value_comp : normalised x_value while in_ready, otherwise 00
//   d_value_comp : normalised d_value while in_ready, otherwise 00
//   q_value      : last captured quotient digit (held between pulses)
//   q_valid      : q_value was updated on the previous edge
//   busy         : a division is in progress (any phase other than IDLE)
//   done         : final cycle of a division
//   stall_cnt    : starved-cycle count (only with DIV_STALL_CNT_EN)
// -----------------------------------------------------------------------------
module online_div_sequencer #(
    parameter int UNROLLING    = 64,
    parameter int ONLINE_DELAY = 3,
    parameter int ADDR_WIDTH   = 7
) (
    input  logic                  clk,
    input  logic                  asyn_reset,
    input  logic                  start,
    input  logic [1:0]            x_value,
    input  logic [1:0]            d_value,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            q_dp,
    output logic                  enable,
    output logic                  refresh,
    output logic [10:0]           counter,
    output logic [10:0]           shift_cnt,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [1:0]            x_value_comp,
    output logic [1:0]            d_value_comp,
    output logic [1:0]            q_value,
    output logic                  q_valid,
    output logic                  busy,
    output logic                  done
`ifdef DIV_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int CW = 11;

    // Counter values at which each phase hands over to the next one.
    localparam logic [CW-1:0] PRELOAD_LAST = CW'(ONLINE_DELAY - 1);
    localparam logic [CW-1:0] ITERATE_LAST = CW'(UNROLLING - 1);
    localparam logic [CW-1:0] FLUSH_LAST   = CW'(UNROLLING + ONLINE_DELAY - 1);
    localparam logic [CW-1:0] DELAY_W      = CW'(ONLINE_DELAY);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PRELOAD = 3'd1;
    localparam logic [2:0] ST_ITERATE = 3'd2;
    localparam logic [2:0] ST_FLUSH   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]    state_reg, state_next;
    logic [CW-1:0] counter_reg, counter_next;
    logic [1:0]    q_value_reg;
    logic          q_valid_reg;

    logic          accepting;     // operand digits are wanted in this cycle
    logic          flushing;
    logic          start_accept;  // a start request that will be honoured
    logic          digit_emit;    // this step produces a quotient digit

    // -------------------------------------------------------------------------
    // Digit normalisation. The code 11 is a second encoding of zero and is
    // folded to 00 before it reaches the datapath or the quotient register.
    // Index 0 = x, index 1 = d, index 2 = q.
    // -------------------------------------------------------------------------
    logic [1:0] digit_raw  [3];
    logic [1:0] digit_norm [3];

    assign digit_raw[0] = x_value;
    assign digit_raw[1] = d_value;
    assign digit_raw[2] = q_dp;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_norm
            assign digit_norm[gi] = (digit_raw[gi] == 2'b11) ? 2'b00 : digit_raw[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Handshake and strobes
    // -------------------------------------------------------------------------
    assign accepting    = (state_reg == ST_PRELOAD) || (state_reg == ST_ITERATE);
    assign flushing     = (state_reg == ST_FLUSH);
    assign start_accept = (state_reg == ST_IDLE) && start;

    assign in_ready = accepting;
    assign enable   = accepting ? in_valid : flushing;

    // While reset is low the state is already IDLE. The extra qualifier stops
    // a start that is held during reset from leaking out as a refresh pulse.
    assign refresh  = start_accept && asyn_reset;

    // The first ONLINE_DELAY steps only prime the datapath. After that, every
    // step produces a quotient digit.
    assign digit_emit = enable && (counter_reg >= DELAY_W);

    assign x_value_comp = in_ready ? digit_norm[0] : 2'b00;
    assign d_value_comp = in_ready ? digit_norm[1] : 2'b00;

    // -------------------------------------------------------------------------
    // Next-state and step counter
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next   = ST_PRELOAD;
                    counter_next = '0;
                end
            end
            ST_PRELOAD: begin
                if (enable) begin
                    counter_next = counter_reg + 1'b1;
                    if (counter_reg == PRELOAD_LAST) begin
                        state_next = ST_ITERATE;
                    end
                end
            end
            ST_ITERATE: begin
                if (enable) begin
                    counter_next = counter_reg + 1'b1;
                    if (counter_reg == ITERATE_LAST) begin
                        state_next = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // The datapath steps every cycle here, so the counter always
                // advances.
                counter_next = counter_reg + 1'b1;
                if (counter_reg == FLUSH_LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // start is deliberately ignored in this cycle.
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge asyn_reset) begin
        if (!asyn_reset) begin
            state_reg   <= ST_IDLE;
            counter_reg <= '0;
            q_value_reg <= 2'b00;
            q_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            q_valid_reg <= digit_emit;
            if (digit_emit) begin
                q_value_reg <= digit_norm[2];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath addressing
    // -------------------------------------------------------------------------
    assign counter   = counter_reg;
    assign shift_cnt = (counter_reg >= DELAY_W) ? (counter_reg - DELAY_W) : '0;
    assign wr_addr   = counter_reg[ADDR_WIDTH-1:0];
    // Reads the slot written by the previous step. Address 0 wraps to all ones.
    assign rd_addr   = wr_addr - ADDR_WIDTH'(1);

    assign q_value = q_value_reg;
    assign q_valid = q_valid_reg;
    assign busy    = (state_reg != ST_IDLE);
    assign done    = (state_reg == ST_DONE);

`ifdef DIV_STALL_CNT_EN
    // -------------------------------------------------------------------------
    // Starvation counter: counts cycles in which operand digits were wanted
    // but none were offered.
    // -------------------------------------------------------------------------
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge asyn_reset) begin
        if (!asyn_reset) begin
            stall_cnt_reg <= '0;
        end else if (start_accept) begin
            stall_cnt_reg <= '0;
        end else if (accepting && !in_valid && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule
